// File: rtl/vga_timing_generator.sv
// vga_timing_generator
//   Raster scan generator: divides the system clock down to the pixel rate and
//   walks a configurable horizontal/vertical timing, presenting registered and
//   mutually aligned pixel coordinates, blank and syncs.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   x, y         coordinates of the presented pixel (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   blank        presented pixel lies outside the active area
//   hsync/vsync  sync outputs, active level SYNC_POL
//   pixel_tick   one-clk pulse in the first cycle of each new pixel
//   line_start   pixel_tick with x==0
//   frame_start  pixel_tick with x==0 and y==0
module vga_timing_generator #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       blank,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_generator: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing_generator: CLK_DIV must be 1..16");
        end
    endgenerate

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit thresholds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG_W = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_W = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG_W = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END_W = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       blank_q, blank_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       tick_q, tick_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    logic [10:0] hc_w, vc_w;
    logic        hs_on, vs_on;

    // The pixel held in (hc,vc) is presented on the edge where div==0 and the
    // counters step on the edge where div==CLK_DIV-1, so the first edge after
    // reset already shows (0,0) and each pixel stays up for CLK_DIV clocks.
    always_comb begin
        hc_w  = {1'b0, hc_q};
        vc_w  = {1'b0, vc_q};
        hs_on = (hc_w >= HS_BEG_W) && (hc_w < HS_END_W);
        vs_on = (vc_w >= VS_BEG_W) && (vc_w < VS_END_W);

        div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (div_q == DIV_LAST) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end

        x_d     = x_q;
        y_d     = y_q;
        blank_d = blank_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        tick_d  = 1'b0;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (div_q == '0) begin
            x_d     = hc_q;
            y_d     = vc_q;
            blank_d = (hc_w >= H_ACT_W) || (vc_w >= V_ACT_W);
            hsync_d = hs_on ? SYNC_POL : ~SYNC_POL;
            vsync_d = vs_on ? SYNC_POL : ~SYNC_POL;
            tick_d  = 1'b1;
            ls_d    = (hc_q == '0);
            fs_d    = (hc_q == '0) && (vc_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            blank_q <= 1'b1;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            tick_q  <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            tick_q  <= tick_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_tick  = tick_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator
//   Three instances: defaults, the small CLK_DIV=1 / active-high-sync variant,
//   and a small CLK_DIV=3 timing. A closed-form model (pixel index = clocks since
//   release / CLK_DIV) predicts every output each clock; predictions are queued
//   at the rising edge and compared at the falling edge.
module tb_vga_timing_generator;

    localparam int P_DIV[3] = '{4, 1, 3};
    localparam int P_HA[3]  = '{640, 8, 10};
    localparam int P_HFP[3] = '{16, 1, 2};
    localparam int P_HS[3]  = '{96, 2, 3};
    localparam int P_HBP[3] = '{48, 1, 2};
    localparam int P_VA[3]  = '{480, 4, 6};
    localparam int P_VFP[3] = '{10, 1, 1};
    localparam int P_VS[3]  = '{2, 1, 2};
    localparam int P_VBP[3] = '{33, 1, 1};
    localparam int P_POL[3] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n[3];
    logic [9:0] xo[3];
    logic [9:0] yo[3];
    logic       bo[3], ho[3], vo[3], pt[3], lso[3], fso[3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vga_timing_generator u0 (
        .clk(clk), .reset(rst_n[0]), .x(xo[0]), .y(yo[0]), .blank(bo[0]),
        .hsync(ho[0]), .vsync(vo[0]), .pixel_tick(pt[0]),
        .line_start(lso[0]), .frame_start(fso[0])
    );

    vga_timing_generator #(
        .CLK_DIV(P_DIV[1]), .H_ACTIVE(P_HA[1]), .H_FP(P_HFP[1]), .H_SYNC(P_HS[1]),
        .H_BP(P_HBP[1]), .V_ACTIVE(P_VA[1]), .V_FP(P_VFP[1]), .V_SYNC(P_VS[1]),
        .V_BP(P_VBP[1]), .SYNC_POL(1'b1)
    ) u1 (
        .clk(clk), .reset(rst_n[1]), .x(xo[1]), .y(yo[1]), .blank(bo[1]),
        .hsync(ho[1]), .vsync(vo[1]), .pixel_tick(pt[1]),
        .line_start(lso[1]), .frame_start(fso[1])
    );

    vga_timing_generator #(
        .CLK_DIV(P_DIV[2]), .H_ACTIVE(P_HA[2]), .H_FP(P_HFP[2]), .H_SYNC(P_HS[2]),
        .H_BP(P_HBP[2]), .V_ACTIVE(P_VA[2]), .V_FP(P_VFP[2]), .V_SYNC(P_VS[2]),
        .V_BP(P_VBP[2]), .SYNC_POL(1'b0)
    ) u2 (
        .clk(clk), .reset(rst_n[2]), .x(xo[2]), .y(yo[2]), .blank(bo[2]),
        .hsync(ho[2]), .vsync(vo[2]), .pixel_tick(pt[2]),
        .line_start(lso[2]), .frame_start(fso[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int h_tot(input int i);
        return P_HA[i] + P_HFP[i] + P_HS[i] + P_HBP[i];
    endfunction

    function automatic int v_tot(input int i);
        return P_VA[i] + P_VFP[i] + P_VS[i] + P_VBP[i];
    endfunction

    // {blank, hsync, vsync} expected for a pixel at (hc, vc)
    function automatic logic [2:0] dec(input int i, input int hc, input int vc);
        bit pol, b, hs_on, vs_on;
        pol   = (P_POL[i] != 0);
        b     = (hc >= P_HA[i]) || (vc >= P_VA[i]);
        hs_on = (hc >= P_HA[i] + P_HFP[i]) && (hc < P_HA[i] + P_HFP[i] + P_HS[i]);
        vs_on = (vc >= P_VA[i] + P_VFP[i]) && (vc < P_VA[i] + P_VFP[i] + P_VS[i]);
        return {b, hs_on ? pol : !pol, vs_on ? pol : !pol};
    endfunction

    // Outputs after the edge that is the t-th edge since reset release.
    function automatic logic [25:0] exp_out(input int i, input int t, input bit in_rst);
        int  p, hc, vc;
        bit  pol, tick;
        logic [2:0] d;
        pol = (P_POL[i] != 0);
        if (in_rst) return {10'd0, 10'd0, 1'b1, !pol, !pol, 3'b000};
        p    = t / P_DIV[i];
        tick = (t % P_DIV[i]) == 0;
        hc   = p % h_tot(i);
        vc   = (p / h_tot(i)) % v_tot(i);
        d    = dec(i, hc, vc);
        return {hc[9:0], vc[9:0], d, tick, tick && (hc == 0), tick && (hc == 0) && (vc == 0)};
    endfunction

    function automatic logic [25:0] act_of(input int i);
        return {xo[i], yo[i], bo[i], ho[i], vo[i], pt[i], lso[i], fso[i]};
    endfunction

    typedef struct {
        int         idx;
        logic [25:0] v;
    } sb_t;

    sb_t sb[$];
    int  t_m[3]      = '{0, 0, 0};
    bit  rst_edge[3] = '{1'b1, 1'b1, 1'b1};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{i, exp_out(i, t_m[i], !rst_n[i])});
            t_m[i]      <= rst_n[i] ? t_m[i] + 1 : 0;
            rst_edge[i] <= !rst_n[i];
        end
    end

    int cnt_h[3]   = '{0, 0, 0};
    int cnt_v[3]   = '{0, 0, 0};
    int last_ls[3] = '{0, 0, 0};
    int last_fs[3] = '{0, 0, 0};
    bit seen_ls[3] = '{1'b0, 1'b0, 1'b0};
    bit seen_fs[3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        sb_t e;
        int  h_on, v_on;
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (sb.size() == 0) begin
                chk($sformatf("u%0d_sb_empty", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("u%0d_out", e.idx), act_of(e.idx), e.v);
            end
            h_on = (ho[i] == P_POL[i][0]) ? 1 : 0;
            v_on = (vo[i] == P_POL[i][0]) ? 1 : 0;
            if (rst_edge[i]) begin
                seen_ls[i] <= 1'b0;
                seen_fs[i] <= 1'b0;
                cnt_h[i]   <= 0;
                cnt_v[i]   <= 0;
            end else begin
                chk($sformatf("u%0d_align", i), {bo[i], ho[i], vo[i]},
                    dec(i, int'(xo[i]), int'(yo[i])));
                if (lso[i]) begin
                    if (seen_ls[i]) begin
                        chk($sformatf("u%0d_hsync_clks", i), cnt_h[i], P_HS[i] * P_DIV[i]);
                        chk($sformatf("u%0d_line_clks", i), cyc - last_ls[i], h_tot(i) * P_DIV[i]);
                    end
                    seen_ls[i] <= 1'b1;
                    last_ls[i] <= cyc;
                    cnt_h[i]   <= h_on;
                end else begin
                    cnt_h[i] <= cnt_h[i] + h_on;
                end
                if (fso[i]) begin
                    if (seen_fs[i]) begin
                        chk($sformatf("u%0d_vsync_clks", i), cnt_v[i],
                            P_VS[i] * h_tot(i) * P_DIV[i]);
                        chk($sformatf("u%0d_frame_clks", i), cyc - last_fs[i],
                            h_tot(i) * v_tot(i) * P_DIV[i]);
                    end
                    seen_fs[i] <= 1'b1;
                    last_fs[i] <= cyc;
                    cnt_v[i]   <= v_on;
                end else begin
                    cnt_v[i] <= cnt_v[i] + v_on;
                end
            end
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // mid-frame reset of the small CLK_DIV=3 timing, after one full frame
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            found = (cyc > 700) && (xo[2] == 10'd5) && (yo[2] == 10'd3) && pt[2];
        end
        chk("u2_reach_mid", found, 1);
        rst_n[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b1;

        // mid-frame reset of the default timing at x=300 on line 1
        found = 1'b0;
        for (int k = 0; k < 8000 && !found; k++) begin
            @(negedge clk);
            found = (xo[0] == 10'd300) && (yo[0] == 10'd1) && pt[0];
        end
        chk("u0_reach_mid", found, 1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;

        // one more full default line plus margin after the restart
        repeat (3400) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
